timer_multi: RTL and testbench

TIMER_MULTI -- requirements
Module: timer_multi

---
 rtl/timer_multi.sv | 118 +++++++++++
 tb/tb_timer_multi.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: bank of independent programmable down-count timers with
// per-channel pending/overrun flags and a lowest-index interrupt encoder.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   wr_en/wr_ch         - configuration write strobe and target channel
//   wr_period           - period P in clk cycles (0 disables the channel)
//   wr_enable           - run enable written together with the period
//   wr_oneshot          - 1 = one-shot, 0 = periodic
//   ack                 - per-channel level acknowledge, clears pending/overrun
//   irq                 - registered per-channel pending flags
//   irq_any / irq_id    - OR of irq / lowest pending channel index (0 if none)
//   overrun             - registered "fired while already pending" flags
//   rd_ch / rd_count    - combinational counter readback (0 if out of range)
module timer_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned IDW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDW-1:0]      wr_ch,
    input  logic [WIDTH-1:0]    wr_period,
    input  logic                wr_enable,
    input  logic                wr_oneshot,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any,
    output logic [IDW-1:0]      irq_id,
    output logic [CHANNELS-1:0] overrun,
    input  logic [IDW-1:0]      rd_ch,
    output logic [WIDTH-1:0]    rd_count
);

    logic [WIDTH-1:0]    period [CHANNELS];
    logic [WIDTH-1:0]    cnt    [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] ovr;

    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] fire;

    // Write decode and fire detection; out-of-range wr_ch matches no channel,
    // and a write to a channel suppresses any fire due on it this cycle.
    always_comb begin
        wr_hit = '0;
        fire   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            wr_hit[i] = wr_en && (wr_ch == IDW'(i));
            fire[i]   = en[i] && !wr_hit[i] && (cnt[i] == '0);
        end
    end

    // Per-channel configuration and counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
            en   <= '0;
            mode <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (wr_hit[i]) begin
                    period[i] <= wr_period;
                    mode[i]   <= wr_oneshot;
                    en[i]     <= wr_enable && (wr_period != '0);
                    cnt[i]    <= (wr_period == '0) ? '0 : wr_period - WIDTH'(1);
                end else if (en[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - WIDTH'(1);
                    end else if (mode[i]) begin
                        en[i] <= 1'b0;
                    end else begin
                        cnt[i] <= period[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    // Pending: a fire beats a same-cycle ack. Overrun: ack always clears it,
    // so a fire coinciding with an ack counts as a fresh event.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            ovr     <= '0;
        end else begin
            pending <= fire | (pending & ~ack);
            ovr     <= ~ack & (ovr | (fire & pending));
        end
    end

    assign irq     = pending;
    assign overrun = ovr;
    assign irq_any = |pending;

    // Lowest-index pending channel wins.
    always_comb begin
        irq_id = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (pending[i]) irq_id = IDW'(i);
        end
    end

    // Counter readback; out-of-range selects read as zero.
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (rd_ch == IDW'(i)) rd_count = cnt[i];
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: a cycle-by-cycle vector table plus
// directed sequences for long periods, priority, one-shot, reset abort, and
// a second instance (5 channels, 4-bit) for out-of-range writes/reads.
module tb_timer_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_period;
    logic       wr_enable;
    logic       wr_oneshot;
    logic [3:0] ack;
    logic [3:0] irq;
    logic       irq_any;
    logic [1:0] irq_id;
    logic [3:0] overrun;
    logic [1:0] rd_ch;
    logic [7:0] rd_count;

    logic       b_wr_en;
    logic [2:0] b_wr_ch;
    logic [3:0] b_wr_period;
    logic       b_wr_enable;
    logic       b_wr_oneshot;
    logic [4:0] b_ack;
    logic [4:0] b_irq;
    logic       b_irq_any;
    logic [2:0] b_irq_id;
    logic [4:0] b_overrun;
    logic [2:0] b_rd_ch;
    logic [3:0] b_rd_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_multi #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_period(wr_period), .wr_enable(wr_enable), .wr_oneshot(wr_oneshot),
        .ack(ack), .irq(irq), .irq_any(irq_any), .irq_id(irq_id),
        .overrun(overrun), .rd_ch(rd_ch), .rd_count(rd_count)
    );

    timer_multi #(.CHANNELS(5), .WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_ch(b_wr_ch),
        .wr_period(b_wr_period), .wr_enable(b_wr_enable), .wr_oneshot(b_wr_oneshot),
        .ack(b_ack), .irq(b_irq), .irq_any(b_irq_any), .irq_id(b_irq_id),
        .overrun(b_overrun), .rd_ch(b_rd_ch), .rd_count(b_rd_count)
    );

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_period;
        logic       wr_enable;
        logic       wr_oneshot;
        logic [3:0] ack;
        logic [1:0] rd_ch;
        logic [3:0] e_irq;
        logic [3:0] e_ovr;
        logic       e_any;
        logic [1:0] e_id;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int ch, input int p, input bit en, input bit os);
        wr_en      = 1'b1;
        wr_ch      = 2'(ch);
        wr_period  = 8'(p);
        wr_enable  = en;
        wr_oneshot = os;
        step();
        wr_en      = 1'b0;
    endtask

    task automatic b_write(input int ch, input int p, input bit en, input bit os);
        b_wr_en      = 1'b1;
        b_wr_ch      = 3'(ch);
        b_wr_period  = 4'(p);
        b_wr_enable  = en;
        b_wr_oneshot = os;
        step();
        b_wr_en      = 1'b0;
    endtask

    // Disable every channel and clear all flags.
    task automatic cleanup();
        for (int c = 0; c < 4; c++) do_write(c, 0, 1'b0, 1'b0);
        ack = 4'hF;
        step();
        ack = 4'h0;
    endtask

    initial begin
        bit flag;

        reset = 1'b1;
        wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_enable = 1'b0; wr_oneshot = 1'b0;
        ack = '0; rd_ch = '0;
        b_wr_en = 1'b0; b_wr_ch = '0; b_wr_period = '0; b_wr_enable = 1'b0;
        b_wr_oneshot = 1'b0; b_ack = '0; b_rd_ch = '0;

        // wr_en, wr_ch, P, enable, oneshot, ack, rd_ch | irq, ovr, any, id, rd
        tbl[0]  = '{1'b1, 2'd1, 8'd2, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd1};
        tbl[1]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[2]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h2, 4'h0, 1'b1, 2'd1, 8'd1};
        tbl[3]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h2, 4'h0, 1'b1, 2'd1, 8'd0};
        tbl[4]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h2, 4'h2, 1'b1, 2'd1, 8'd1};
        tbl[5]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h2, 4'h2, 1'b1, 2'd1, 8'd0};
        tbl[6]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h2, 2'd1, 4'h2, 4'h0, 1'b1, 2'd1, 8'd1};
        tbl[7]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h2, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[8]  = '{1'b1, 2'd1, 8'd0, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[9]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[10] = '{1'b1, 2'd3, 8'd1, 1'b1, 1'b0, 4'h0, 2'd3, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[11] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd3, 4'h8, 4'h0, 1'b1, 2'd3, 8'd0};
        tbl[12] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd3, 4'h8, 4'h8, 1'b1, 2'd3, 8'd0};
        tbl[13] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h8, 2'd3, 4'h8, 4'h0, 1'b1, 2'd3, 8'd0};
        tbl[14] = '{1'b1, 2'd3, 8'd4, 1'b0, 1'b0, 4'h8, 2'd3, 4'h0, 4'h0, 1'b0, 2'd0, 8'd3};
        tbl[15] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd3, 4'h0, 4'h0, 1'b0, 2'd0, 8'd3};
        tbl[16] = '{1'b1, 2'd0, 8'd3, 1'b1, 1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd2};
        tbl[17] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd1};
        tbl[18] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[19] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h1, 4'h0, 1'b1, 2'd0, 8'd0};
        tbl[20] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h1, 4'h0, 1'b1, 2'd0, 8'd0};
        tbl[21] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h1, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0};

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("reset_irq", int'(irq), 0);
        check("reset_ovr", int'(overrun), 0);
        check("reset_any", int'(irq_any), 0);
        check("reset_id", int'(irq_id), 0);
        check("reset_rd", int'(rd_count), 0);
        check("reset_b_irq", int'(b_irq), 0);

        // Cycle-by-cycle table
        for (int r = 0; r < 22; r++) begin
            wr_en      = tbl[r].wr_en;
            wr_ch      = tbl[r].wr_ch;
            wr_period  = tbl[r].wr_period;
            wr_enable  = tbl[r].wr_enable;
            wr_oneshot = tbl[r].wr_oneshot;
            ack        = tbl[r].ack;
            rd_ch      = tbl[r].rd_ch;
            step();
            check($sformatf("row%0d_irq", r), int'(irq), int'(tbl[r].e_irq));
            check($sformatf("row%0d_ovr", r), int'(overrun), int'(tbl[r].e_ovr));
            check($sformatf("row%0d_any", r), int'(irq_any), int'(tbl[r].e_any));
            check($sformatf("row%0d_id", r), int'(irq_id), int'(tbl[r].e_id));
            check($sformatf("row%0d_rd", r), int'(rd_count), int'(tbl[r].e_rd));
        end
        wr_en = 1'b0;
        ack   = '0;
        cleanup();

        // Periodic P=7 on ch0, ack pulsed the cycle after each fire
        do_write(0, 7, 1'b1, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            ack = ((k % 7) == 1 && k > 1) ? 4'h1 : 4'h0;
            step();
            check($sformatf("p7_irq0_k%0d", k), int'(irq[0]), int'((k % 7) == 0));
            if ((k % 7) == 0) check($sformatf("p7_id_k%0d", k), int'(irq_id), 0);
        end
        ack = '0;
        cleanup();

        // Simultaneous fires and priority: ch3 P=6 then ch1 P=5 line up
        do_write(3, 6, 1'b1, 1'b0);
        do_write(1, 5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        check("prio_before", int'(irq), 0);
        step();
        check("prio_irq", int'(irq), 4'hA);
        check("prio_any", int'(irq_any), 1);
        check("prio_id", int'(irq_id), 1);
        ack = 4'h2;
        step();
        ack = 4'h0;
        check("prio_ack_irq", int'(irq), 4'h8);
        check("prio_ack_id", int'(irq_id), 3);
        cleanup();

        // Maximum period 255
        do_write(2, 255, 1'b1, 1'b0);
        rd_ch = 2'd2;
        #1;
        check("p255_rd", int'(rd_count), 254);
        flag = 1'b0;
        for (int k = 1; k <= 254; k++) begin
            step();
            if (irq[2]) flag = 1'b1;
        end
        check("p255_early", int'(flag), 0);
        step();
        check("p255_fire", int'(irq[2]), 1);
        check("p255_id", int'(irq_id), 2);
        cleanup();

        // P=0 with enable never fires
        do_write(0, 0, 1'b1, 1'b0);
        rd_ch = 2'd0;
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (irq != 4'h0 || rd_count != 8'd0) flag = 1'b1;
        end
        check("p0_never", int'(flag), 0);

        // One-shot P=3 on ch2
        do_write(2, 3, 1'b1, 1'b1);
        rd_ch = 2'd2;
        step();
        step();
        check("os_before", int'(irq), 0);
        step();
        check("os_fire", int'(irq), 4'h4);
        ack = 4'h4;
        step();
        ack = 4'h0;
        flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (irq != 4'h0 || overrun != 4'h0) flag = 1'b1;
        end
        check("os_no_refire", int'(flag), 0);
        check("os_rd", int'(rd_count), 0);
        cleanup();

        // Reset mid-count dominates a write and ack in the same cycle
        do_write(3, 1, 1'b1, 1'b0);
        do_write(0, 7, 1'b1, 1'b0);
        step(); step(); step();
        check("rst_pre_irq3", int'(irq[3]), 1);
        check("rst_pre_ovr3", int'(overrun[3]), 1);
        reset = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd1; wr_period = 8'd1; wr_enable = 1'b1; wr_oneshot = 1'b0;
        ack = 4'hF;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        ack = 4'h0;
        rd_ch = 2'd0;
        #1;
        check("rst_irq", int'(irq), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_any", int'(irq_any), 0);
        check("rst_id", int'(irq_id), 0);
        check("rst_rd0", int'(rd_count), 0);
        flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (irq != 4'h0) flag = 1'b1;
        end
        check("rst_idle", int'(flag), 0);

        // Second instance: out-of-range writes/reads and 4-bit max period
        b_write(0, 9, 1'b1, 1'b0);
        b_rd_ch = 3'd0;
        #1;
        check("b_rd0_a", int'(b_rd_count), 8);
        b_write(5, 3, 1'b1, 1'b0);
        b_write(6, 2, 1'b1, 1'b0);
        b_write(7, 1, 1'b1, 1'b0);
        check("b_rd0_b", int'(b_rd_count), 5);
        b_rd_ch = 3'd5;
        #1;
        check("b_rd5", int'(b_rd_count), 0);
        b_rd_ch = 3'd7;
        #1;
        check("b_rd7", int'(b_rd_count), 0);
        flag = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (b_irq != 5'h0) flag = 1'b1;
        end
        check("b_oor_quiet", int'(flag), 0);
        step();
        check("b_fire0", int'(b_irq), 1);
        check("b_any", int'(b_irq_any), 1);
        check("b_id", int'(b_irq_id), 0);
        b_write(4, 15, 1'b1, 1'b0);
        flag = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (b_irq[4]) flag = 1'b1;
        end
        check("b_p15_early", int'(flag), 0);
        step();
        check("b_p15_fire", int'(b_irq[4]), 1);
        check("b_p15_ovr", int'(b_overrun[4]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
